// File: rtl/inst_rom_arb_pkg.sv
// Shared constants for the instruction-ROM arbiter: bus widths, reset and chip-enable levels.
// Constants only; no types are defined here.
package inst_rom_arb_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord = '0;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    // Reset is active-low: rst at this level holds the block in reset.
    localparam logic RstEnable = 1'b0;

endpackage

// File: rtl/inst_rom_arb_slot.sv
// Purpose: per-port response register holding one ROM word behind a valid/ready handshake.
// Latency: word loaded on the edge after grant, presented from the next cycle.
// Backpressure: holds valid and data stable while rsp_ready is low; drains and reloads in one cycle.
// Optional: INST_ROM_ARB_ALIGN_CHK_EN adds an error flag loaded alongside the word.
module inst_rom_arb_slot
    import inst_rom_arb_pkg::*;
#(
    parameter int DATA_W = InstBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] ld_inst,
`ifdef INST_ROM_ARB_ALIGN_CHK_EN
    input  logic              ld_err,
    output logic              rsp_err,
`endif
    input  logic              rsp_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_inst
);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            rsp_valid <= 1'b0;
        end else if (load) begin
            rsp_valid <= 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Data only moves on a load, so a drained slot keeps its last word.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            rsp_inst <= DATA_W'(ZeroWord);
        end else if (load) begin
            rsp_inst <= ld_inst;
        end
    end

`ifdef INST_ROM_ARB_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            rsp_err <= 1'b0;
        end else if (load) begin
            rsp_err <= ld_err;
        end
    end
`endif

endmodule

// File: rtl/inst_rom_arb.sv
// Purpose: two-port arbiter/sequencer for a single-ported combinational-read instruction ROM.
// Latency: request accepted in cycle N returns its word from cycle N+1; one ROM access per cycle.
// Backpressure: a port is only granted when its response slot is empty or draining this cycle.
// Optional: INST_ROM_ARB_ALIGN_CHK_EN flags misaligned requests with rsp*_err instead of reading the ROM.
module inst_rom_arb
    import inst_rom_arb_pkg::*;
#(
    parameter int ADDR_W       = InstAddrBus,
    parameter int DATA_W       = InstBus,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,

    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_inst,
    input  logic              rsp0_ready,

    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_inst,
    input  logic              rsp1_ready,

`ifdef INST_ROM_ARB_ALIGN_CHK_EN
    output logic              rsp0_err,
    output logic              rsp1_err,
`endif

    output logic              mem_ce,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_inst
);

    localparam logic [CNT_W-1:0] StarveLim = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    logic             live;
    logic             elig0;
    logic             elig1;
    logic             grant0;
    logic             grant1;
    logic             any_grant;
    logic             misaligned;
    logic [DATA_W-1:0] ld_inst;
    logic [CNT_W-1:0] starve_cnt;

    // Grants are suppressed combinationally while reset is held.
    assign live  = (rst != RstEnable);
    assign elig0 = live & en & req0_valid & (~rsp0_valid | rsp0_ready);
    assign elig1 = live & en & req1_valid & (~rsp1_valid | rsp1_ready);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            if (starve_cnt >= StarveLim) begin
                grant1 = 1'b1;
            end else begin
                grant0 = 1'b1;
            end
        end else if (elig0) begin
            grant0 = 1'b1;
        end else if (elig1) begin
            grant1 = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign any_grant  = grant0 | grant1;

    always_comb begin
        mem_addr = '0;
        if (grant0) begin
            mem_addr = req0_addr;
        end else if (grant1) begin
            mem_addr = req1_addr;
        end
    end

`ifdef INST_ROM_ARB_ALIGN_CHK_EN
    assign misaligned = (mem_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned access still completes on schedule but never touches the ROM.
    assign mem_ce  = (any_grant & ~misaligned) ? ChipEnable : ChipDisable;
    assign ld_inst = misaligned ? DATA_W'(ZeroWord) : mem_inst;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            starve_cnt <= '0;
        end else if (!req1_valid || grant1) begin
            starve_cnt <= '0;
        end else if (elig1 && (starve_cnt != CntMax)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    inst_rom_arb_slot #(
        .DATA_W    (DATA_W)
    ) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .load      (grant0),
        .ld_inst   (ld_inst),
`ifdef INST_ROM_ARB_ALIGN_CHK_EN
        .ld_err    (misaligned),
        .rsp_err   (rsp0_err),
`endif
        .rsp_ready (rsp0_ready),
        .rsp_valid (rsp0_valid),
        .rsp_inst  (rsp0_inst)
    );

    inst_rom_arb_slot #(
        .DATA_W    (DATA_W)
    ) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (grant1),
        .ld_inst   (ld_inst),
`ifdef INST_ROM_ARB_ALIGN_CHK_EN
        .ld_err    (misaligned),
        .rsp_err   (rsp1_err),
`endif
        .rsp_ready (rsp1_ready),
        .rsp_valid (rsp1_valid),
        .rsp_inst  (rsp1_inst)
    );

endmodule

// File: tb/tb_inst_rom_arb.sv
// Bench for inst_rom_arb: directed scenarios plus a randomized run against a behavioural model.
// Build with INST_ROM_ARB_ALIGN_CHK_EN defined to also cover the alignment checker.
module tb_inst_rom_arb;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_inst, rsp1_inst;
    logic        rsp0_ready, rsp1_ready;
    logic        mem_ce;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
`ifdef INST_ROM_ARB_ALIGN_CHK_EN
    logic        rsp0_err, rsp1_err;
`endif

    logic [31:0] rom [0:63];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_inst = rom[mem_addr[7:2]];

    inst_rom_arb #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_inst(rsp0_inst), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_inst(rsp1_inst), .rsp1_ready(rsp1_ready),
`ifdef INST_ROM_ARB_ALIGN_CHK_EN
        .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
`endif
        .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_inst(mem_inst)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        en         = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1;
        req0_valid = 1'b1; req0_addr = 32'h4;
        req1_valid = 1'b1; req1_addr = 32'h8;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #2;
        checks++;
        if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready, mem_ce} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000",
                     {rsp0_valid, rsp1_valid, req0_ready, req1_ready, mem_ce});
        end
        tick(); tick();
        checks++;
        if (rsp0_inst !== 32'h0 || rsp1_inst !== 32'h0 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held got inst0=%h inst1=%h v0=%b want 0 0 0", rsp0_inst, rsp1_inst, rsp0_valid);
        end
        @(negedge clk);
        rst = 1'b1; req1_valid = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || mem_addr !== 32'h4 || mem_ce !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_accept got rdy=%b addr=%h ce=%b want 1 00000004 1", req0_ready, mem_addr, mem_ce);
        end
        tick();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_inst !== rom[1]) begin
            errors++;
            $display("FAIL reset_first_rsp got v=%b inst=%h want 1 %h", rsp0_valid, rsp0_inst, rom[1]);
        end
        req0_valid = 1'b0; rsp0_ready = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        idle();
        req0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_addr = 32'(4 * i);
            #1;
            checks++;
            if (req0_ready !== 1'b1 || mem_addr !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_accept[%0d] got rdy=%b addr=%h want 1 %h", i, req0_ready, mem_addr, 4 * i);
            end
            tick();
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_inst !== rom[i]) begin
                errors++;
                $display("FAIL stream_rsp[%0d] got v=%b inst=%h want 1 %h", i, rsp0_valid, rsp0_inst, rom[i]);
            end
        end
        req0_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        idle();
        req0_valid = 1'b1; req0_addr = 32'h10; rsp0_ready = 1'b0;
        #1;
        tick();
        req0_addr = 32'h14;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready[%0d] got %b want 0", i, req0_ready);
            end
            tick();
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_inst !== rom[4]) begin
                errors++;
                $display("FAIL bp_stable[%0d] got v=%b inst=%h want 1 %h", i, rsp0_valid, rsp0_inst, rom[4]);
            end
        end
        rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain_accept got %b want 1", req0_ready);
        end
        tick();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_inst !== rom[5]) begin
            errors++;
            $display("FAIL bp_next_rsp got v=%b inst=%h want 1 %h", rsp0_valid, rsp0_inst, rom[5]);
        end
        req0_valid = 1'b0;
    endtask

    task automatic test_starvation();
        bit exp1;
        idle();
        req0_valid = 1'b1; req0_addr = 32'h20;
        req1_valid = 1'b1; req1_addr = 32'h40;
        for (int c = 0; c < 15; c++) begin
            exp1 = ((c % 5) == 4);
            #1;
            checks++;
            if (req1_ready !== exp1 || req0_ready !== !exp1) begin
                errors++;
                $display("FAIL starve_grant[%0d] got r0=%b r1=%b want %b %b", c, req0_ready, req1_ready, !exp1, exp1);
            end
            tick();
            if (exp1) begin
                checks++;
                if (rsp1_valid !== 1'b1 || rsp1_inst !== rom[16]) begin
                    errors++;
                    $display("FAIL starve_rsp1[%0d] got v=%b inst=%h want 1 %h", c, rsp1_valid, rsp1_inst, rom[16]);
                end
            end
        end
        idle();
    endtask

    task automatic test_enable();
        idle();
        req0_valid = 1'b1; req0_addr = 32'h8; rsp0_ready = 1'b0;
        #1;
        tick();
        en = 1'b0; rsp0_ready = 1'b1; req0_addr = 32'hC;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || mem_ce !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL en_low_grant got rdy=%b ce=%b addr=%h want 0 0 0", req0_ready, mem_ce, mem_addr);
        end
        tick();
        checks++;
        if (rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_low_drain got v=%b want 0", rsp0_valid);
        end
        en = 1'b1;
        #1;
        tick();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_inst !== rom[3]) begin
            errors++;
            $display("FAIL en_resume got v=%b inst=%h want 1 %h", rsp0_valid, rsp0_inst, rom[3]);
        end
        // Starvation count must freeze while disabled: 2 before, 3 frozen, then 2 more before port 1 wins.
        idle();
        req0_valid = 1'b1; req0_addr = 32'h0;
        req1_valid = 1'b1; req1_addr = 32'h4;
        repeat (2) tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req1_ready !== (c == 2)) begin
                errors++;
                $display("FAIL en_starve_hold[%0d] got r1=%b want %b", c, req1_ready, (c == 2));
            end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        req0_valid = 1'b1; req0_addr = 32'h4; rsp0_ready = 1'b0;
        #1;
        tick();
        req0_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (rsp0_valid !== 1'b0 || rsp0_inst !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got v=%b inst=%h want 0 0", rsp0_valid, rsp0_inst);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

`ifdef INST_ROM_ARB_ALIGN_CHK_EN
    task automatic test_align();
        idle();
        req1_valid = 1'b1; req1_addr = 32'h6;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || mem_ce !== 1'b0) begin
            errors++;
            $display("FAIL align_grant got rdy=%b ce=%b want 1 0", req1_ready, mem_ce);
        end
        tick();
        req1_valid = 1'b0;
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b1 || rsp1_inst !== 32'h0) begin
            errors++;
            $display("FAIL align_rsp got v=%b err=%b inst=%h want 1 1 0", rsp1_valid, rsp1_err, rsp1_inst);
        end
        idle();
    endtask
`endif

    task automatic test_random();
        bit          occ0, occ1, e0, e1, g0, g1, exp_ce;
        logic [31:0] d0, d1, exp_addr;
        bit          er0, er1, mis;
        int          starve;
        logic [5:0]  idx;
        idle();
        occ0 = 0; occ1 = 0; d0 = '0; d1 = '0; er0 = 0; er1 = 0; starve = 0;
        for (int n = 0; n < 400; n++) begin
            checks++;
            if (rsp0_valid !== occ0 || (occ0 && rsp0_inst !== d0)) begin
                errors++;
                $display("FAIL rand_rsp0[%0d] got v=%b inst=%h want %b %h", n, rsp0_valid, rsp0_inst, occ0, d0);
            end
            checks++;
            if (rsp1_valid !== occ1 || (occ1 && rsp1_inst !== d1)) begin
                errors++;
                $display("FAIL rand_rsp1[%0d] got v=%b inst=%h want %b %h", n, rsp1_valid, rsp1_inst, occ1, d1);
            end
`ifdef INST_ROM_ARB_ALIGN_CHK_EN
            checks++;
            if ((occ0 && rsp0_err !== er0) || (occ1 && rsp1_err !== er1)) begin
                errors++;
                $display("FAIL rand_err[%0d] got %b%b want %b%b", n, rsp0_err, rsp1_err, er0, er1);
            end
`endif
            en         = ($urandom_range(0, 9) != 0);
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 1) != 0);
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            idx = 6'($urandom_range(0, 63));
            req0_addr = {24'd0, idx, 2'b00};
            idx = 6'($urandom_range(0, 63));
            req1_addr = {24'd0, idx, 2'b00};
`ifdef INST_ROM_ARB_ALIGN_CHK_EN
            if ($urandom_range(0, 3) == 0) req0_addr[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) req1_addr[1:0] = 2'($urandom_range(1, 3));
`endif
            #1;
            e0 = en && req0_valid && (!occ0 || rsp0_ready);
            e1 = en && req1_valid && (!occ1 || rsp1_ready);
            g1 = e1 && (!e0 || starve >= LIMIT);
            g0 = e0 && !g1;
            exp_addr = g0 ? req0_addr : (g1 ? req1_addr : 32'h0);
`ifdef INST_ROM_ARB_ALIGN_CHK_EN
            mis = (exp_addr[1:0] != 2'b00);
`else
            mis = 1'b0;
`endif
            exp_ce = (g0 || g1) && !mis;
            checks++;
            if (req0_ready !== g0 || req1_ready !== g1 || mem_ce !== exp_ce || mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL rand_grant[%0d] got r=%b%b ce=%b addr=%h want %b%b %b %h",
                         n, req0_ready, req1_ready, mem_ce, mem_addr, g0, g1, exp_ce, exp_addr);
            end
            if (!req1_valid || g1) starve = 0;
            else if (e1) starve = (starve < 7) ? starve + 1 : 7;
            if (g0) begin
                occ0 = 1; d0 = mis ? 32'h0 : rom[exp_addr[7:2]]; er0 = mis;
            end else if (rsp0_ready) begin
                occ0 = 0;
            end
            if (g1) begin
                occ1 = 1; d1 = mis ? 32'h0 : rom[exp_addr[7:2]]; er1 = mis;
            end else if (rsp1_ready) begin
                occ1 = 0;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rst = 1'b0; en = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; rsp0_ready = 1'b0;
        req1_valid = 1'b0; req1_addr = '0; rsp1_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_starvation();
        test_enable();
        test_async_reset();
`ifdef INST_ROM_ARB_ALIGN_CHK_EN
        test_align();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
